// File: rtl/mux_4_1_rr_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter: FSM state encoding,
// mux select index constants and the round-robin winner search.
// Pure combinational helpers; no latency, no backpressure of their own.
package mux_4_1_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    localparam logic [1:0] SEL_I0 = 2'b00;
    localparam logic [1:0] SEL_I1 = 2'b01;
    localparam logic [1:0] SEL_I2 = 2'b10;
    localparam logic [1:0] SEL_I3 = 2'b11;

    // Returns {found, index}. The search visits ptr, ptr+1, ptr+2, ptr+3
    // (mod 4); iterating from the farthest offset down lets the nearest hit
    // overwrite. With no hit, the index falls back to ptr so the mux selects
    // stay parked on the current priority slot.
    function automatic logic [2:0] rr_pick(input logic [3:0] req_vec,
                                           input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = {1'b0, ptr};
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req_vec[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_4_1_n_bit.sv
// N-bit 4:1 multiplexer; {s1,s0} picks one of i0..i3 onto y.
// Latency: purely combinational, zero cycles.
// Backpressure: none, the output follows the selects and inputs directly.
// Ports: i0..i3 data inputs, s0/s1 select bits (s1 is the MSB), y selected word.
module mux_4_1_n_bit
    import mux_4_1_rr_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i0,
    input  logic [N-1:0] i1,
    input  logic [N-1:0] i2,
    input  logic [N-1:0] i3,
    input  logic         s0,
    input  logic         s1,
    output logic [N-1:0] y
);

    always_comb begin
        y = i0;
        case ({s1, s0})
            SEL_I0:  y = i0;
            SEL_I1:  y = i1;
            SEL_I2:  y = i2;
            SEL_I3:  y = i3;
            default: y = i0;
        endcase
    end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter sharing one N-bit 4:1 mux between four requesters;
// the winning word is registered and offered downstream with valid/ready.
// Latency: one cycle from req to out_valid; 1 word/cycle when out_ready holds.
// Backpressure: with out_valid & ~out_ready everything freezes (no ack, no pointer move).
// Ports: clk/rst_n; req[3:0] + i0..i3 from producers; ack[3:0] one-cycle capture
// pulse back to them; out_data/out_valid/out_ready/gnt_id towards the consumer.
module mux_4_1_rr_arbiter
    import mux_4_1_rr_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [N-1:0] i0,
    input  logic [N-1:0] i1,
    input  logic [N-1:0] i2,
    input  logic [N-1:0] i3,
    output logic [3:0]   ack,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   gnt_id
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_ptr;
    logic [3:0]     r_ack;
    logic [N-1:0]   r_data;
    logic [1:0]     r_gnt;

    logic [3:0]     w_req_eff;
    logic           w_found;
    logic [1:0]     w_win;
    logic           w_s0;
    logic           w_s1;
    logic [N-1:0]   w_mux;
    logic           w_arb_en;
    logic           w_capture;

    // A requester still shows req during the cycle its ack is high (it only
    // has to react by the following edge), so mask it to avoid granting the
    // same word twice.
    assign w_req_eff = req & ~r_ack;

    assign {w_found, w_win} = rr_pick(w_req_eff, r_ptr);
    assign w_s0 = w_win[0];
    assign w_s1 = w_win[1];

    assign w_arb_en  = (r_state == ST_IDLE) || ((r_state == ST_FULL) && out_ready);
    assign w_capture = w_arb_en && w_found;

    mux_4_1_n_bit #(.N(N)) u_mux (
        .i0 (i0),
        .i1 (i1),
        .i2 (i2),
        .i3 (i3),
        .s0 (w_s0),
        .s1 (w_s1),
        .y  (w_mux)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A capture always lands in FULL, even when it coincides with an accept;
    // an accept with nothing to capture drains back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (w_capture) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && out_ready) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= 2'b00;
            r_ack  <= 4'b0000;
            r_data <= '0;
            r_gnt  <= 2'b00;
        end else begin
            r_ack <= 4'b0000;
            if (w_capture) begin
                r_data <= w_mux;
                r_gnt  <= w_win;
                r_ack  <= 4'b0001 << w_win;
                r_ptr  <= w_win + 2'd1;
            end
        end
    end

    assign ack       = r_ack;
    assign out_data  = r_data;
    assign out_valid = (r_state == ST_FULL);
    assign gnt_id    = r_gnt;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Self-checking bench for mux_4_1_rr_arbiter: directed vector table, reset
// corner sequences, then randomized traffic against a behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mux_4_1_rr_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [N-1:0] d [4];
    logic [3:0]   ack;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   gnt_id;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    bit         m_valid;
    bit [3:0]   m_ack;
    bit [N-1:0] m_data;
    int         m_gnt;
    int         m_ptr;

    typedef struct {
        bit [3:0]   req;
        bit         ready;
        bit [3:0]   exp_ack;
        bit         exp_valid;
        bit [N-1:0] exp_data;
        bit [1:0]   exp_gnt;
    } vec_t;

    vec_t tbl [21];

    always #5 clk = ~clk;

    mux_4_1_rr_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .i0        (d[0]),
        .i1        (d[1]),
        .i2        (d[2]),
        .i3        (d[3]),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gnt_id    (gnt_id)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_ack   = 4'b0000;
        m_data  = '0;
        m_gnt   = 0;
        m_ptr   = 0;
    endtask

    // Predicts the registered outputs after the next rising edge from the
    // current inputs, using the arbitration rules directly.
    task automatic model_edge();
        bit [3:0] elig;
        int       win;
        elig = req & ~m_ack;
        win  = -1;
        if ((!m_valid || out_ready) && (elig != 4'b0000)) begin
            for (int j = 0; j < 4; j++) begin
                if (win < 0 && elig[(m_ptr + j) % 4]) win = (m_ptr + j) % 4;
            end
        end
        if (win >= 0) begin
            m_data  = d[win];
            m_gnt   = win;
            m_ack   = 4'b0000;
            m_ack[win] = 1'b1;
            m_ptr   = (win + 1) % 4;
            m_valid = 1;
        end else begin
            m_ack = 4'b0000;
            if (m_valid && out_ready) m_valid = 0;
        end
    endtask

    initial begin
        // {req, ready, exp_ack, exp_valid, exp_data, exp_gnt}
        tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 4'h2, 2'd0};
        tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 4'h6, 2'd1};
        tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 4'hF, 2'd2};
        tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
        tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 4'h2, 2'd0};
        for (int i = 5; i < 10; i++)
            tbl[i] = '{4'hF, 1'b0, 4'b0000, 1'b1, 4'h2, 2'd0};
        tbl[10] = '{4'hF, 1'b1, 4'b0010, 1'b1, 4'h6, 2'd1};
        tbl[11] = '{4'h0, 1'b1, 4'b0000, 1'b0, 4'h6, 2'd1};
        tbl[12] = '{4'h0, 1'b1, 4'b0000, 1'b0, 4'h6, 2'd1};
        tbl[13] = '{4'h4, 1'b1, 4'b0100, 1'b1, 4'hF, 2'd2};
        tbl[14] = '{4'h0, 1'b1, 4'b0000, 1'b0, 4'hF, 2'd2};
        tbl[15] = '{4'h8, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
        tbl[16] = '{4'h0, 1'b1, 4'b0000, 1'b0, 4'h8, 2'd3};
        tbl[17] = '{4'h9, 1'b1, 4'b0001, 1'b1, 4'h2, 2'd0};
        tbl[18] = '{4'h9, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3};
        tbl[19] = '{4'h2, 1'b1, 4'b0010, 1'b1, 4'h6, 2'd1};
        tbl[20] = '{4'h0, 1'b0, 4'b0000, 1'b1, 4'h6, 2'd1};

        // Reset held with every requester active
        rst_n     = 1'b0;
        req       = 4'hF;
        out_ready = 1'b1;
        d[0] = 4'h2; d[1] = 4'h6; d[2] = 4'hF; d[3] = 4'h8;
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ack",   32'(ack),       32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_gnt",   32'(gnt_id),    32'd0);

        // Directed table
        rst_n = 1'b1;
        for (int i = 0; i < 21; i++) begin
            req       = tbl[i].req;
            out_ready = tbl[i].ready;
            step();
            check($sformatf("tbl%0d_ack", i),   32'(ack),       32'(tbl[i].exp_ack));
            check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_data", i),  32'(out_data),  32'(tbl[i].exp_data));
            check($sformatf("tbl%0d_gnt", i),   32'(gnt_id),    32'(tbl[i].exp_gnt));
        end

        // Reset mid-transfer: word held, consumer stalled, pointer at 2
        rst_n = 1'b0;
        #1;
        check("midrst_valid_async", 32'(out_valid), 32'd0);
        check("midrst_data_async",  32'(out_data),  32'd0);
        check("midrst_gnt_async",   32'(gnt_id),    32'd0);
        check("midrst_ack_async",   32'(ack),       32'd0);
        req = 4'hF;
        step();
        check("midrst_ack_edge",    32'(ack),       32'd0);
        check("midrst_valid_edge",  32'(out_valid), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check("postrst_gnt",  32'(gnt_id),   32'd0);
        check("postrst_data", 32'(out_data), 32'h2);
        check("postrst_ack",  32'(ack),      32'b0001);

        // Randomized traffic against the model
        rst_n = 1'b0;
        req   = 4'h0;
        step();
        model_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (m_ack[k] || !req[k]) begin
                    req[k] = 1'($urandom_range(0, 1));
                    d[k]   = N'($urandom);
                end else if ($urandom_range(0, 9) == 0) begin
                    req[k] = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            model_edge();
            step();
            check("rnd_ack",   32'(ack),       32'(m_ack));
            check("rnd_valid", 32'(out_valid), 32'(m_valid));
            check("rnd_data",  32'(out_data),  32'(m_data));
            check("rnd_gnt",   32'(gnt_id),    32'(m_gnt));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_4_1_rr_arbiter.md
Name: mux_4_1_rr_arbiter

Overview:
Shares one N-bit 4:1 mux datapath between four requesters using round-robin arbitration. Each requester holds `req[k]` high with stable data on `ik`. The block selects a winner, drives the mux selects, and captures the winner's word into an output register. It then presents that word downstream with a valid/ready handshake. It sits between four producer blocks and a single consumer port.

Parameters:
N, 4, data width of each input word and of `out_data`

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset; one clock, reset is asynchronous and active-low
req  input  4  `req[k]` = requester k has a word on `ik`; held until `ack[k]`
i0  input  N  requester 0 data, stable while `req[0]`=1
i1  input  N  requester 1 data
i2  input  N  requester 2 data
i3  input  N  requester 3 data
ack  output  4  one-cycle pulse; `ack[k]`=1 in the cycle `ik` is captured
out_data  output  N  registered selected word
out_valid  output  1  `out_data` holds an unconsumed word
out_ready  input  1  consumer accepts `out_data` when `out_valid` & `out_ready`
gnt_id  output  2  registered index of requester whose word is in `out_data`

Behaviour:
- Reset (async, `rst_n`=0): `out_valid`=0, `out_data`=0, `ack`=4'b0000, `gnt_id`=2'b00, priority pointer `ptr`=2'b00, state IDLE. Effect is immediate and independent of `clk`. This applies mid-transfer too: any held word is dropped and no ack is issued for it.
- States:
  - IDLE: `out_valid`=0.
  - FULL: `out_valid`=1.
- Arbitration-enable: `arb_en` = (state==IDLE) | (state==FULL & `out_ready`).
- Winner: the first k with `req[k]`=1, searching `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4). Combinational.
- Mux selects: `{s1,s0}` = winner index (`s1` MSB). The mux routes `i[{s1,s0}]`: 00→`i0`, 01→`i1`, 10→`i2`, 11→`i3`. When there is no winner, selects hold `ptr`.
- Capture edge (`arb_en` & `|req`):
  - `out_data` <= mux output.
  - `gnt_id` <= winner.
  - `ack[winner]` <= 1; all other ack bits 0.
  - `ptr` <= winner+1 (3 wraps to 0).
  - State <= FULL.
- Accept with no pending request (FULL & `out_ready` & ~`|req`): `out_valid`→0, state→IDLE. `out_data` and `gnt_id` hold their last values.
- FULL & ~`out_ready`: everything holds, no ack, `ptr` frozen.
- Latency and throughput:
  - `req` rise in IDLE → capture at the next edge → `out_valid`=1 one cycle after `req` rises.
  - Back-to-back accept and capture in the same cycle gives 1 word/cycle sustained.
- `ack` is registered. A requester sees `ack[k]`=1 in the cycle after capture and must drop or replace `req[k]`/`ik` by the following edge. Arbitration ignores `req[k]` during the cycle `ack[k]`=1 to prevent a double grant.
- `out_ready` while `out_valid`=0: ignored.
- `req` withdrawn before capture: allowed, no ack, no effect.
- Fairness: a continuously requesting k is granted within 4 captures.
- No arithmetic beyond the 2-bit wrap of `ptr`; `out_data` is a pure copy (no width change).

Decomposition:
- Shared include `mux_4_1_defs.vh`:
  - state encodings `ST_IDLE`=1'b0, `ST_FULL`=1'b1.
  - select index constants `SEL_I0`..`SEL_I3` (2'b00..2'b11).
- Sub-module: instantiate the existing `mux_4_1_n_bit` (#(N)) for the data path, driven by `s0`/`s1` from the winner logic.
- Round-robin priority search and FSM stay in this module.

Test Plan:
- Reset: hold `rst_n`=0 with `req`=4'b1111 → `out_valid`=0, `ack`=0, `out_data`=0, `gnt_id`=0. Release, `out_ready`=1 → capture order 0,1,2,3,0.
- Single request, N=4, `i2`=4'b1111, `req`=4'b0100, `out_ready`=1 → next cycle `out_data`=4'b1111, `gnt_id`=2, `ack`=4'b0100 for exactly one cycle.
- All requesting with `i0`=0010, `i1`=0110, `i2`=1111, `i3`=1000, `out_ready`=1 → `out_data` sequence 0010, 0110, 1111, 1000, 0010 on consecutive cycles; `out_valid` stays 1.
- Backpressure: `out_ready`=0 for 5 cycles after the first capture with `req`=1111 → `out_data`=0010 held, `ack`=0, `ptr` frozen. Set `out_ready`=1 → next capture is `i1` (0110).
- Pointer wrap: grant 3 (`req`=1000), then `req`=1001 → next grant is 0, not 3.
- Reset mid-transfer: assert `rst_n`=0 while `out_valid`=1, `out_ready`=0 → `out_valid` drops asynchronously the same cycle and no ack fires. After release, the first grant is from `ptr`=0.
